eth_host_sequencer: RTL and testbench
=====================================

ETH_HOST_SEQUENCER -- requirements
Module: eth_host_sequencer

Interface
REQ-001 Parameters: DATA_W, default 60, word width of the host and processor data buses.
REQ-002 Parameters: ADDR_W, default 11, address width; one polynomial memory holds 2**ADDR_W words.
REQ-003 Parameters: TIMEOUT, default 2**24, the maximum number of cycles to wait for done_comp.
REQ-004 Port: clk  in  1  single clock for all logic. Reset is asynchronous and active-low.
REQ-005 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-006 Port: cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
REQ-007 Port: cmd_op  in  2  command: 0 = LOAD_POLY, 1 = LOAD_PROG, 2 = RUN, 3 = READ_POLY.
REQ-008 Port: cmd_proc  in  3  processor select, 0-6; cmd_mem  in  4  memory select, 1-9; cmd_len  in  ADDR_W+1  word count, 1..2**ADDR_W.
REQ-009 Port: din_valid / din_ready / din  in / out / in  1 / 1 / DATA_W  host write-data stream.
REQ-010 Port: dout_valid / dout_ready / dout  out / in / out  1 / 1 / DATA_W  read-back stream.
REQ-011 Port: interrupt_eth, web_eth, wep_eth  out  1 each  processor-array load strobes.
REQ-012 Port: address_eth  out  ADDR_W; dinb_eth  out  DATA_W; instruction_eth  out  8; operand_eth  out  8.
REQ-013 Port: doutb_eth  in  DATA_W  memory read data; valid exactly one cycle after the address is presented.
REQ-014 Port: done_comp  in  1  computation done. busy, err_timeout, err_cmd  out  1 each  status.

Function
REQ-015 FSM states: IDLE, LOAD, PROG, RUN_ISSUE, RUN_WAIT, READ, DRAIN.
REQ-016 cmd_ready is 1 only in IDLE; a command is accepted on a cycle where cmd_valid and cmd_ready are both 1, and its fields are latched.
REQ-017 Command checks: cmd_proc > 6, cmd_mem of 0 or > 9, or a cmd_len outside its range -> pulse err_cmd for 1 cycle and stay in IDLE.
REQ-018 operand_eth = {cmd_proc, 1'b0, cmd_mem}, i.e. (proc<<5)+mem, held constant for the whole command.
REQ-019 LOAD_POLY: interrupt_eth = 1 and instruction_eth = 1 throughout; din_ready = 1.
REQ-020 LOAD_POLY: each accepted din word drives web_eth = 1, dinb_eth = din, and address_eth = word index (starting at 0) in the same registered cycle.
REQ-021 LOAD_POLY: web_eth = 0 on cycles with no word accepted; after cmd_len words, go to IDLE and drop interrupt_eth and instruction_eth to 0 on the next cycle.
REQ-022 LOAD_PROG: same flow as LOAD_POLY but with wep_eth instead of web_eth, interrupt_eth = 0, instruction_eth = 0, and address starting at 0.
REQ-023 LOAD_PROG: the host must terminate the program with opcode 255 in bits [7:0]; the block does not check this.
REQ-024 RUN: RUN_ISSUE drives instruction_eth = 65 for exactly 1 cycle, then moves to RUN_WAIT with instruction_eth = 0.
REQ-025 RUN_WAIT: done_comp = 1 -> IDLE. The cycle counter reaching TIMEOUT -> pulse err_timeout for 1 cycle, then IDLE.
REQ-026 READ_POLY: interrupt_eth = 1, instruction_eth = 2, web_eth = 0; addresses 0..cmd_len-1 are issued.
REQ-027 READ_POLY: the captured doutb_eth words go into a 2-entry output FIFO; a new address is issued only if (FIFO occupancy + in-flight reads) < 2, so no word is ever lost under dout_ready backpressure.
REQ-028 After the last address is issued, go to DRAIN; leave DRAIN for IDLE when the FIFO is empty and no read is in flight.
REQ-029 Output ordering: dout words follow address order; dout_valid/dout are unchanged while dout_valid = 1 and dout_ready = 0.
REQ-030 busy = 1 in every state except IDLE.
REQ-031 Address counter is ADDR_W+1 bits; address_eth = counter[ADDR_W-1:0]; cmd_len = 2**ADDR_W ends at address 2**ADDR_W-1 with no wrap.
REQ-032 All outputs to the processor array are registered, with no combinational path from host inputs to the *_eth outputs.

Reset
REQ-033 reset_n = 0 at any time (including mid-command) -> FSM = IDLE immediately; all counters, the FIFO, and every output go to 0, except cmd_ready, which is 1 once reset_n = 1.
REQ-034 A command cut short by reset is abandoned; it does not resume.

Verification
REQ-035 LOAD_POLY proc = 3, mem = 4, len = 2048, din_valid always 1 -> operand_eth = 100; 2048 web_eth pulses at addresses 0..2047; busy for 2048 cycles plus overhead.
REQ-036 LOAD_POLY len = 4 with din_valid gaps every other cycle -> exactly 4 web_eth pulses at addresses 0-3, each with the matching din data.
REQ-037 LOAD_PROG of 14 words ending in 255, then RUN with done_comp raised 50 cycles later -> wep_eth pulses at addresses 0-13, one instruction_eth = 65 pulse, IDLE one cycle after done_comp.
REQ-038 RUN with done_comp held at 0 and TIMEOUT = 100 -> err_timeout pulses in cycle 100 of RUN_WAIT, then IDLE.
REQ-039 READ_POLY len = 8 with dout_ready toggling randomly and doutb_eth = address*3 -> dout sequence 0, 3, ..., 21, with no loss and no duplicates.
REQ-040 cmd_proc = 7 -> err_cmd pulse and no *_eth activity; then reset_n asserted midway through a READ_POLY with len = 2048 -> all outputs 0, and the next command is accepted normally.

Source files
------------

// File: rtl/eth_host_sequencer.sv
// rtl/eth_host_sequencer.sv - host command sequencer driving the processor-array load, run and read-back strobes
module eth_host_sequencer #(
    parameter int DATA_W  = 60,
    parameter int ADDR_W  = 11,
    parameter int TIMEOUT = 2**24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [2:0]        cmd_proc,
    input  logic [3:0]        cmd_mem,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [DATA_W-1:0] din,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] dout,
    output logic              interrupt_eth,
    output logic              web_eth,
    output logic              wep_eth,
    output logic [ADDR_W-1:0] address_eth,
    output logic [DATA_W-1:0] dinb_eth,
    output logic [7:0]        instruction_eth,
    output logic [7:0]        operand_eth,
    input  logic [DATA_W-1:0] doutb_eth,
    input  logic              done_comp,
    output logic              busy,
    output logic              err_timeout,
    output logic              err_cmd
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_PROG, S_RUN_ISSUE, S_RUN_WAIT, S_READ, S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d, len_q, len_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [7:0]        operand_q, operand_d, instr_q, instr_d;
    logic              interrupt_q, interrupt_d, web_q, web_d, wep_q, wep_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dinb_q, dinb_d;
    logic              err_timeout_q, err_timeout_d, err_cmd_q, err_cmd_d;
    logic              pend1_q, pend1_d, pend2_q, pend2_d;
    logic [DATA_W-1:0] fifo_q [2];
    logic [DATA_W-1:0] fifo_d [2];
    logic              wptr_q, wptr_d, rptr_q, rptr_d;
    logic [1:0]        fcnt_q, fcnt_d;

    logic       din_fire, pop, issue, bad_cmd;
    logic [2:0] tokens;

    assign cmd_ready       = reset_n && (state_q == S_IDLE);
    assign din_ready       = (state_q == S_LOAD) || (state_q == S_PROG);
    assign dout_valid      = (fcnt_q != 2'd0);
    assign dout            = fifo_q[rptr_q];
    assign busy            = (state_q != S_IDLE);
    assign interrupt_eth   = interrupt_q;
    assign web_eth         = web_q;
    assign wep_eth         = wep_q;
    assign address_eth     = addr_q;
    assign dinb_eth        = dinb_q;
    assign instruction_eth = instr_q;
    assign operand_eth     = operand_q;
    assign err_timeout     = err_timeout_q;
    assign err_cmd         = err_cmd_q;

    assign din_fire = din_valid && din_ready;
    assign pop      = dout_valid && dout_ready;
    // FIFO slots plus reads still in the memory pipeline must never exceed two
    assign tokens   = 3'(fcnt_q) + 3'(pend1_q) + 3'(pend2_q);
    assign issue    = (state_q == S_READ) && (cnt_q != len_q) && (tokens < 3'd2);
    assign bad_cmd  = (cmd_proc > 3'd6) || (cmd_mem == 4'd0) || (cmd_mem > 4'd9) ||
                      (cmd_len == '0) || (cmd_len > MAX_LEN);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        len_d         = len_q;
        tmo_d         = tmo_q;
        operand_d     = operand_q;
        instr_d       = instr_q;
        interrupt_d   = interrupt_q;
        web_d         = 1'b0;
        wep_d         = 1'b0;
        addr_d        = addr_q;
        dinb_d        = dinb_q;
        err_timeout_d = 1'b0;
        err_cmd_d     = 1'b0;
        pend1_d       = issue;
        pend2_d       = pend1_q;
        fifo_d        = fifo_q;
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        fcnt_d        = fcnt_q + {1'b0, pend2_q} - {1'b0, pop};
        if (pend2_q) begin
            fifo_d[wptr_q] = doutb_eth;
            wptr_d         = ~wptr_q;
        end
        if (pop) begin
            rptr_d = ~rptr_q;
        end

        case (state_q)
            S_IDLE: begin
                interrupt_d = 1'b0;
                instr_d     = 8'd0;
                if (cmd_valid) begin
                    if (bad_cmd) begin
                        err_cmd_d = 1'b1;
                    end else begin
                        len_d     = cmd_len;
                        cnt_d     = '0;
                        operand_d = {cmd_proc, 1'b0, cmd_mem};
                        case (cmd_op)
                            2'd0: begin
                                state_d     = S_LOAD;
                                interrupt_d = 1'b1;
                                instr_d     = 8'd1;
                            end
                            2'd1: state_d = S_PROG;
                            2'd2: begin
                                state_d = S_RUN_ISSUE;
                                instr_d = 8'd65;
                            end
                            default: begin
                                state_d     = S_READ;
                                interrupt_d = 1'b1;
                                instr_d     = 8'd2;
                            end
                        endcase
                    end
                end
            end
            S_LOAD, S_PROG: begin
                if (din_fire) begin
                    web_d  = (state_q == S_LOAD);
                    wep_d  = (state_q == S_PROG);
                    dinb_d = din;
                    addr_d = cnt_q[ADDR_W-1:0];
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == len_q) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_RUN_ISSUE: begin
                instr_d = 8'd0;
                tmo_d   = TW'(1);
                state_d = S_RUN_WAIT;
            end
            S_RUN_WAIT: begin
                // tmo_q equals the RUN_WAIT cycle number, so the error shows in cycle TIMEOUT
                if (done_comp || err_timeout_q) begin
                    state_d = S_IDLE;
                end else if (tmo_q >= TW'(TIMEOUT - 1)) begin
                    err_timeout_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_READ: begin
                if (issue) begin
                    addr_d = cnt_q[ADDR_W-1:0];
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == len_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if ((fcnt_q == 2'd0) && !pend1_q && !pend2_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            len_q         <= '0;
            tmo_q         <= '0;
            operand_q     <= '0;
            instr_q       <= '0;
            interrupt_q   <= 1'b0;
            web_q         <= 1'b0;
            wep_q         <= 1'b0;
            addr_q        <= '0;
            dinb_q        <= '0;
            err_timeout_q <= 1'b0;
            err_cmd_q     <= 1'b0;
            pend1_q       <= 1'b0;
            pend2_q       <= 1'b0;
            fifo_q        <= '{default: '0};
            wptr_q        <= 1'b0;
            rptr_q        <= 1'b0;
            fcnt_q        <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            len_q         <= len_d;
            tmo_q         <= tmo_d;
            operand_q     <= operand_d;
            instr_q       <= instr_d;
            interrupt_q   <= interrupt_d;
            web_q         <= web_d;
            wep_q         <= wep_d;
            addr_q        <= addr_d;
            dinb_q        <= dinb_d;
            err_timeout_q <= err_timeout_d;
            err_cmd_q     <= err_cmd_d;
            pend1_q       <= pend1_d;
            pend2_q       <= pend2_d;
            fifo_q        <= fifo_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            fcnt_q        <= fcnt_d;
        end
    end

endmodule

// File: tb/tb_eth_host_sequencer.sv
// tb/tb_eth_host_sequencer.sv - directed self-checking bench for eth_host_sequencer
module tb_eth_host_sequencer;
    localparam int DW = 60;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [2:0]    cmd_proc;
    logic [3:0]    cmd_mem;
    logic [AW:0]   cmd_len;
    logic          din_valid, din_ready;
    logic [DW-1:0] din;
    logic          dout_valid, dout_ready;
    logic [DW-1:0] dout;
    logic          interrupt_eth, web_eth, wep_eth;
    logic [AW-1:0] address_eth;
    logic [DW-1:0] dinb_eth;
    logic [7:0]    instruction_eth, operand_eth;
    logic [DW-1:0] doutb_eth = '0;
    logic          done_comp;
    logic          busy, err_timeout, err_cmd;

    always #5 clk = ~clk;

    eth_host_sequencer #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(100)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_proc(cmd_proc), .cmd_mem(cmd_mem), .cmd_len(cmd_len),
        .din_valid(din_valid), .din_ready(din_ready), .din(din),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
        .interrupt_eth(interrupt_eth), .web_eth(web_eth), .wep_eth(wep_eth),
        .address_eth(address_eth), .dinb_eth(dinb_eth),
        .instruction_eth(instruction_eth), .operand_eth(operand_eth),
        .doutb_eth(doutb_eth), .done_comp(done_comp),
        .busy(busy), .err_timeout(err_timeout), .err_cmd(err_cmd)
    );

    // synchronous memory: data for an address appears one cycle after it is presented
    always @(posedge clk) doutb_eth <= DW'(address_eth) * 60'd3;

    int unsigned   web_n = 0, wep_n = 0, i65_n = 0, errt_n = 0, busy_n = 0;
    int unsigned   bad_web = 0, bad_wep = 0;
    logic [AW-1:0] web_a[$], wep_a[$];
    logic [DW-1:0] web_d[$], wep_d[$];

    always @(negedge clk) begin
        if (web_eth) begin
            web_n++;
            web_a.push_back(address_eth);
            web_d.push_back(dinb_eth);
            if (interrupt_eth !== 1'b1 || instruction_eth !== 8'd1) bad_web++;
        end
        if (wep_eth) begin
            wep_n++;
            wep_a.push_back(address_eth);
            wep_d.push_back(dinb_eth);
            if (interrupt_eth !== 1'b0 || instruction_eth !== 8'd0) bad_wep++;
        end
        if (instruction_eth == 8'd65) i65_n++;
        if (err_timeout) errt_n++;
        if (busy) busy_n++;
    end

    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] word(input int i, input int len, input bit ffend);
        logic [DW-1:0] d;
        d = {28'h00A5C3E, 32'(i * 13 + 5)};
        if (ffend && i == len - 1) d[7:0] = 8'hFF;
        return d;
    endfunction

    task automatic send_cmd(input logic [1:0] op, input logic [2:0] p, input logic [3:0] m,
                            input logic [AW:0] l);
        int w;
        w = 0;
        while (!cmd_ready && w < 50) begin
            step();
            w++;
        end
        if (w >= 50) check("cmd_ready_wait", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_proc  = p;
        cmd_mem   = m;
        cmd_len   = l;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic feed(input int len, input bit gap, input bit ffend);
        int  idx, cyc;
        bit  acc;
        idx = 0;
        cyc = 0;
        while (idx < len && cyc < 10000) begin
            din_valid = gap ? (cyc % 2 == 0) : 1'b1;
            din       = word(idx, len, ffend);
            acc       = din_valid && din_ready;
            step();
            if (acc) idx++;
            cyc++;
        end
        din_valid = 1'b0;
        if (cyc >= 10000) check("feed_timeout", 64'(idx), 64'(len));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_web, s_wep, s_busy, s_i65, s_errt, bad, first_err, first_idle, unstable;
        logic [DW-1:0] rx[$];
        logic [DW-1:0] prev_dout;
        bit            prev_stall;

        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_proc = '0; cmd_mem = '0;
        cmd_len = '0; din_valid = 1'b0; din = '0; dout_ready = 1'b0; done_comp = 1'b0;
        repeat (3) step();
        check("rst_cmd_ready_low", 64'(cmd_ready), 64'(0));
        reset_n = 1'b1;
        step();
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_outputs", 64'({busy, interrupt_eth, web_eth, wep_eth, instruction_eth,
                                  operand_eth, dout_valid, din_ready, err_cmd, err_timeout}), 64'(0));

        // LOAD_POLY full memory, din always valid
        s_web = web_a.size(); s_busy = busy_n;
        send_cmd(2'd0, 3'd3, 4'd4, 12'd2048);
        check("load_operand", 64'(operand_eth), 64'(100));
        check("load_intr_instr", 64'({interrupt_eth, instruction_eth}), 64'({1'b1, 8'd1}));
        feed(2048, 1'b0, 1'b0);
        repeat (3) step();
        check("load2048_pulses", 64'(web_a.size() - s_web), 64'(2048));
        bad = 0;
        for (int i = 0; i < 2048; i++)
            if (web_a[s_web + i] !== AW'(i) || web_d[s_web + i] !== word(i, 2048, 1'b0)) bad++;
        check("load2048_addr_data", 64'(bad), 64'(0));
        check("load2048_busy_cycles", 64'(busy_n - s_busy), 64'(2048));
        check("load_ctx_bad", 64'(bad_web), 64'(0));
        check("load_end_intr_instr", 64'({interrupt_eth, instruction_eth}), 64'(0));

        // LOAD_POLY with valid gaps
        s_web = web_a.size();
        send_cmd(2'd0, 3'd1, 4'd9, 12'd4);
        check("gap_operand", 64'(operand_eth), 64'(41));
        feed(4, 1'b1, 1'b0);
        repeat (3) step();
        check("gap_pulses", 64'(web_a.size() - s_web), 64'(4));
        bad = 0;
        for (int i = 0; i < 4; i++)
            if (web_a[s_web + i] !== AW'(i) || web_d[s_web + i] !== word(i, 4, 1'b0)) bad++;
        check("gap_addr_data", 64'(bad), 64'(0));

        // LOAD_PROG then RUN finished by done_comp
        s_web = web_a.size(); s_wep = wep_a.size();
        send_cmd(2'd1, 3'd0, 4'd2, 12'd14);
        check("prog_intr_instr_operand", 64'({interrupt_eth, instruction_eth, operand_eth}),
              64'({1'b0, 8'd0, 8'd2}));
        feed(14, 1'b0, 1'b1);
        repeat (3) step();
        check("prog_pulses", 64'(wep_a.size() - s_wep), 64'(14));
        bad = 0;
        for (int i = 0; i < 14; i++)
            if (wep_a[s_wep + i] !== AW'(i) || wep_d[s_wep + i] !== word(i, 14, 1'b1)) bad++;
        check("prog_addr_data", 64'(bad), 64'(0));
        check("prog_last_opcode", 64'(wep_d[s_wep + 13][7:0]), 64'(255));
        check("prog_no_web", 64'(web_a.size() - s_web), 64'(0));
        check("prog_ctx_bad", 64'(bad_wep), 64'(0));

        s_i65 = i65_n; s_errt = errt_n;
        send_cmd(2'd2, 3'd0, 4'd2, 12'd1);
        check("run_instr65", 64'(instruction_eth), 64'(65));
        repeat (50) step();
        check("run_busy_waiting", 64'({busy, instruction_eth}), 64'({1'b1, 8'd0}));
        done_comp = 1'b1;
        step();
        check("run_done_idle", 64'(busy), 64'(0));
        done_comp = 1'b0;
        check("run_one_issue", 64'(i65_n - s_i65), 64'(1));
        check("run_no_timeout", 64'(errt_n - s_errt), 64'(0));

        // RUN with no done_comp: timeout
        s_errt = errt_n;
        send_cmd(2'd2, 3'd6, 4'd9, 12'd1);
        check("tmo_instr65", 64'(instruction_eth), 64'(65));
        first_err = 0; first_idle = 0;
        for (int k = 1; k <= 200; k++) begin
            step();
            if (err_timeout && first_err == 0) first_err = k;
            if (!busy) begin
                first_idle = k;
                break;
            end
        end
        check("tmo_err_cycle", 64'(first_err), 64'(100));
        check("tmo_idle_cycle", 64'(first_idle), 64'(101));
        check("tmo_one_pulse", 64'(errt_n - s_errt), 64'(1));

        // READ_POLY with random backpressure
        s_web = web_a.size();
        send_cmd(2'd3, 3'd2, 4'd3, 12'd8);
        check("read_intr_instr_operand", 64'({interrupt_eth, instruction_eth, operand_eth}),
              64'({1'b1, 8'd2, 8'd67}));
        unstable = 0; prev_stall = 1'b0; prev_dout = '0;
        for (int c = 0; c < 400; c++) begin
            dout_ready = 1'($urandom_range(0, 1));
            if (prev_stall && (dout_valid !== 1'b1 || dout !== prev_dout)) unstable++;
            if (dout_valid && dout_ready) rx.push_back(dout);
            prev_stall = dout_valid && !dout_ready;
            prev_dout  = dout;
            step();
            if (rx.size() == 8 && !busy) break;
        end
        dout_ready = 1'b0;
        repeat (3) step();
        check("read_count", 64'(rx.size()), 64'(8));
        bad = 0;
        for (int i = 0; i < rx.size(); i++)
            if (rx[i] !== DW'(i * 3)) bad++;
        check("read_sequence", 64'(bad), 64'(0));
        check("read_stall_stable", 64'(unstable), 64'(0));
        check("read_end_state", 64'({busy, dout_valid, interrupt_eth, instruction_eth}), 64'(0));
        check("read_no_web", 64'(web_a.size() - s_web), 64'(0));

        // bad commands
        s_web = web_n; s_wep = wep_n; s_i65 = i65_n;
        send_cmd(2'd0, 3'd7, 4'd4, 12'd4);
        check("errcmd_proc7", 64'({err_cmd, busy}), 64'({1'b1, 1'b0}));
        step();
        check("errcmd_one_cycle", 64'(err_cmd), 64'(0));
        send_cmd(2'd0, 3'd3, 4'd0, 12'd4);
        check("errcmd_mem0", 64'(err_cmd), 64'(1));
        step();
        send_cmd(2'd3, 3'd3, 4'd4, 12'd2049);
        check("errcmd_len2049", 64'(err_cmd), 64'(1));
        step();
        repeat (3) step();
        check("errcmd_no_activity", 64'({16'(web_n - s_web), 16'(wep_n - s_wep), 16'(i65_n - s_i65)}), 64'(0));
        check("errcmd_operand_kept", 64'({interrupt_eth, operand_eth}), 64'({1'b0, 8'd67}));

        // reset in the middle of a long read
        send_cmd(2'd3, 3'd5, 4'd5, 12'd2048);
        dout_ready = 1'b1;
        repeat (100) step();
        check("midread_busy", 64'(busy), 64'(1));
        reset_n = 1'b0;
        #1;
        check("midreset_ctrl_zero", 64'({interrupt_eth, web_eth, wep_eth, address_eth, instruction_eth,
                                        operand_eth, busy, err_timeout, err_cmd, dout_valid,
                                        din_ready, cmd_ready}), 64'(0));
        check("midreset_data_zero", 64'({dinb_eth[31:0], dout[31:0]}), 64'(0));
        repeat (2) step();
        reset_n = 1'b1;
        step();
        check("post_reset_ready", 64'({cmd_ready, busy, dout_valid}), 64'({1'b1, 1'b0, 1'b0}));
        s_web = web_a.size();
        send_cmd(2'd0, 3'd3, 4'd4, 12'd2);
        check("post_reset_accept", 64'({busy, operand_eth}), 64'({1'b1, 8'd100}));
        feed(2, 1'b0, 1'b0);
        repeat (3) step();
        check("post_reset_pulses", 64'(web_a.size() - s_web), 64'(2));
        bad = 0;
        for (int i = 0; i < 2; i++)
            if (web_a[s_web + i] !== AW'(i) || web_d[s_web + i] !== word(i, 2, 1'b0)) bad++;
        check("post_reset_addr_data", 64'(bad), 64'(0));
        check("post_reset_no_resume", 64'({dout_valid, busy}), 64'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
